// File: rtl/sfifo_wr_arb_if.sv
// Push-side bundle between the requesters, the write arbiter and the sfifo.
// The arbiter takes the master view; the requesters and FIFO sit on the slave view.
interface sfifo_wr_arb_if #(
    parameter int NREQ   = 4,
    parameter int FIFO_D = 12,
    parameter int FIFO_W = 32
);
    localparam int FIFO_ADR = $clog2(FIFO_D);

    logic [NREQ-1:0]        req_vld;
    logic [NREQ*FIFO_W-1:0] req_dat;
    logic [NREQ-1:0]        req_rdy;
    logic                   fifo_we;
    logic [FIFO_W-1:0]      fifo_wd;
    logic                   fifo_fsh;
    logic                   fifo_full;
    logic                   fifo_ovf;
    logic [FIFO_ADR:0]      fifo_len;

    modport master (
        input  req_vld, req_dat, fifo_full, fifo_ovf, fifo_len,
        output req_rdy, fifo_we, fifo_wd, fifo_fsh
    );

    modport slave (
        output req_vld, req_dat, fifo_full, fifo_ovf, fifo_len,
        input  req_rdy, fifo_we, fifo_wd, fifo_fsh
    );
endinterface

// File: rtl/sfifo_wr_arb.sv
// Round-robin push arbiter for the sfifo with credit check and flush sequencing.
// state  | meaning
// ARB    | round-robin grant to requesters while credit allows
// FDRAIN | no grants; the last registered write lands in the FIFO
// FSH    | fifo_fsh pulse is on the FIFO
// FDONE  | fsh_done pulse to the system, then back to ARB
module sfifo_wr_arb #(
    parameter int NREQ   = 4,
    parameter int FIFO_D = 12,
    parameter int FIFO_W = 32
) (
    input  logic                           clk,
    input  logic                           rstn,
    sfifo_wr_arb_if.master                 bus,
    input  logic                           fsh_req,
    output logic                           fsh_done,
    output logic [$clog2(NREQ)-1:0]        gnt_id,
    output logic                           ovf_err
);
    localparam int FIFO_ADR = $clog2(FIFO_D);
    localparam int IDW      = $clog2(NREQ);
    localparam int OCC_W    = FIFO_ADR + 2;

    typedef enum logic [1:0] {
        ARB    = 2'd0,
        FDRAIN = 2'd1,
        FSH    = 2'd2,
        FDONE  = 2'd3
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [IDW-1:0]   rr_ptr;
    logic [IDW-1:0]   win;
    logic [IDW-1:0]   cand;
    logic             found;
    logic [OCC_W-1:0] occ;
    logic             can_wr;
    logic             grant;

    // fifo_len lags our own registered write by a cycle, so count it in
    assign occ    = OCC_W'(bus.fifo_len) + OCC_W'(bus.fifo_we);
    assign can_wr = (occ < OCC_W'(FIFO_D)) && !bus.fifo_full;

    always_comb begin
        win   = '0;
        cand  = '0;
        found = 1'b0;
        for (int k = 1; k <= NREQ; k++) begin
            cand = IDW'((int'(rr_ptr) + k) % NREQ);
            if (!found && bus.req_vld[cand]) begin
                win   = cand;
                found = 1'b1;
            end
        end
    end

    // a newly seen flush wins over any requester in the same cycle
    assign grant = rstn && (state == ARB) && !fsh_req && found && can_wr;

    always_comb begin
        bus.req_rdy      = '0;
        bus.req_rdy[win] = grant;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ARB:     if (fsh_req) state_nxt = FDRAIN;
            FDRAIN:  state_nxt = FSH;
            FSH:     state_nxt = FDONE;
            FDONE:   state_nxt = ARB;
            default: state_nxt = ARB;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state        <= ARB;
            rr_ptr       <= IDW'(NREQ - 1);
            gnt_id       <= '0;
            bus.fifo_we  <= 1'b0;
            bus.fifo_wd  <= '0;
            bus.fifo_fsh <= 1'b0;
            fsh_done     <= 1'b0;
            ovf_err      <= 1'b0;
        end else begin
            state        <= state_nxt;
            bus.fifo_we  <= grant;
            bus.fifo_fsh <= (state == FDRAIN);
            fsh_done     <= (state == FSH);
            ovf_err      <= ovf_err | bus.fifo_ovf;
            if (grant) begin
                bus.fifo_wd <= bus.req_dat[int'(win)*FIFO_W +: FIFO_W];
                gnt_id      <= win;
                rr_ptr      <= win;
            end
        end
    end
endmodule

// File: tb/tb_sfifo_wr_arb.sv
// Directed bench for sfifo_wr_arb with a small FIFO occupancy model on the push side.
module tb_sfifo_wr_arb;
    localparam int NREQ   = 4;
    localparam int FIFO_D = 12;
    localparam int FIFO_W = 32;

    logic       clk;
    logic       rstn;
    logic       fsh_req;
    logic       fsh_done;
    logic [1:0] gnt_id;
    logic       ovf_err;

    logic       pop;
    logic       ovf_force;
    logic       ld_en;
    logic [4:0] ld_val;
    logic [4:0] len = '0;

    int total = 0;
    int bad   = 0;

    sfifo_wr_arb_if #(.NREQ(NREQ), .FIFO_D(FIFO_D), .FIFO_W(FIFO_W)) bus ();

    sfifo_wr_arb #(.NREQ(NREQ), .FIFO_D(FIFO_D), .FIFO_W(FIFO_W)) dut (
        .clk      (clk),
        .rstn     (rstn),
        .bus      (bus),
        .fsh_req  (fsh_req),
        .fsh_done (fsh_done),
        .gnt_id   (gnt_id),
        .ovf_err  (ovf_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // FIFO occupancy: pushes land one edge after fifo_we, pops only when non-empty
    always @(posedge clk) begin
        if (!rstn)             len <= '0;
        else if (ld_en)        len <= ld_val;
        else if (bus.fifo_fsh) len <= '0;
        else len <= len + {4'd0, bus.fifo_we} - {4'd0, (pop && len != 5'd0)};
    end

    assign bus.fifo_len  = len;
    assign bus.fifo_full = (len >= 5'(FIFO_D));
    assign bus.fifo_ovf  = ovf_force | (bus.fifo_we && len >= 5'(FIFO_D) && !pop);

    function automatic logic [31:0] dat_of(input int i);
        return 32'hA5A5_0010 + 32'(i);
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #2;
    endtask

    task automatic settle;
        #1;
    endtask

    task automatic load(input logic [4:0] v);
        ld_val = v;
        ld_en  = 1'b1;
        tick();
        ld_en  = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int acc;
        int first_zero;

        rstn        = 1'b0;
        fsh_req     = 1'b0;
        pop         = 1'b0;
        ovf_force   = 1'b0;
        ld_en       = 1'b0;
        ld_val      = '0;
        bus.req_vld = 4'hF;
        for (int i = 0; i < NREQ; i++) bus.req_dat[i*FIFO_W +: FIFO_W] = dat_of(i);

        // reset values; req_rdy must stay low while in reset even with requests
        #1;
        chk("rst_rdy", 32'(bus.req_rdy), 32'h0);
        tick();
        tick();
        chk("rst_we",   32'(bus.fifo_we),  32'h0);
        chk("rst_wd",   bus.fifo_wd,       32'h0);
        chk("rst_fsh",  32'(bus.fifo_fsh), 32'h0);
        chk("rst_done", 32'(fsh_done),     32'h0);
        chk("rst_gnt",  32'(gnt_id),       32'h0);
        chk("rst_ovf",  32'(ovf_err),      32'h0);
        bus.req_vld = 4'h0;
        rstn = 1'b1;
        tick();

        // all requesters valid, FIFO popped continuously: order 0,1,2,3,0
        pop = 1'b1;
        bus.req_vld = 4'hF;
        for (int c = 0; c < 5; c++) begin
            settle();
            chk("rr_rdy", 32'(bus.req_rdy), 32'h1 << (c % 4));
            tick();
            chk("rr_we",  32'(bus.fifo_we), 32'h1);
            chk("rr_wd",  bus.fifo_wd,      dat_of(c % 4));
            chk("rr_gnt", 32'(gnt_id),      32'(c % 4));
        end
        bus.req_vld = 4'h0;
        tick();
        chk("idle_we", 32'(bus.fifo_we), 32'h0);
        chk("idle_wd", bus.fifo_wd,      dat_of(0));
        repeat (4) tick();
        pop = 1'b0;
        chk("drain_len", 32'(len), 32'h0);

        // only requester 2, no pops: exactly FIFO_D beats before credit runs out
        bus.req_vld = 4'b0100;
        acc = 0;
        first_zero = -1;
        for (int c = 0; c < 14; c++) begin
            settle();
            if (bus.req_rdy[2]) acc++;
            else if (first_zero < 0) first_zero = c;
            tick();
        end
        chk("fill_acc",   32'(acc),           32'd12);
        chk("fill_drop",  32'(first_zero),    32'd12);
        chk("fill_gnt",   32'(gnt_id),        32'd2);
        chk("fill_full",  32'(bus.fifo_full), 32'h1);
        chk("fill_ovf",   32'(bus.fifo_ovf),  32'h0);
        chk("fill_err",   32'(ovf_err),       32'h0);
        bus.req_vld = 4'h0;
        load(5'd0);

        // one slot left: req 0 takes it, req 1 right after sees no credit
        load(5'd11);
        bus.req_vld = 4'b0001;
        settle();
        chk("edge_rdy0", 32'(bus.req_rdy), 32'b0001);
        tick();
        chk("edge_we",  32'(bus.fifo_we), 32'h1);
        chk("edge_gnt", 32'(gnt_id),      32'h0);
        bus.req_vld = 4'b0010;
        settle();
        chk("edge_rdy1", 32'(bus.req_rdy), 32'h0);
        tick();
        settle();
        chk("edge_rdy2", 32'(bus.req_rdy),  32'h0);
        chk("edge_full", 32'(bus.fifo_full), 32'h1);
        bus.req_vld = 4'h0;
        load(5'd0);

        // flush raised with req 3 valid and a write in flight
        bus.req_vld = 4'b1000;
        settle();
        chk("fl_pre_rdy", 32'(bus.req_rdy), 32'b1000);
        tick();
        fsh_req = 1'b1;
        settle();
        chk("fl_arb_rdy", 32'(bus.req_rdy), 32'h0);
        tick();
        chk("fl_drain_we",  32'(bus.fifo_we),  32'h0);
        chk("fl_drain_fsh", 32'(bus.fifo_fsh), 32'h0);
        chk("fl_drain_len", 32'(len),          32'h1);
        chk("fl_drain_rdy", 32'(bus.req_rdy),  32'h0);
        tick();
        chk("fl_fsh",      32'(bus.fifo_fsh), 32'h1);
        chk("fl_fsh_done", 32'(fsh_done),     32'h0);
        chk("fl_fsh_rdy",  32'(bus.req_rdy),  32'h0);
        tick();
        chk("fl_done",     32'(fsh_done),     32'h1);
        chk("fl_done_fsh", 32'(bus.fifo_fsh), 32'h0);
        chk("fl_empty",    32'(len),          32'h0);
        fsh_req = 1'b0;
        settle();
        chk("fl_done_rdy", 32'(bus.req_rdy), 32'h0);
        tick();
        chk("fl_post_done", 32'(fsh_done),    32'h0);
        chk("fl_post_rdy",  32'(bus.req_rdy), 32'b1000);
        tick();
        chk("fl_post_we",  32'(bus.fifo_we), 32'h1);
        chk("fl_post_gnt", 32'(gnt_id),      32'd3);
        chk("fl_post_wd",  bus.fifo_wd,      dat_of(3));
        bus.req_vld = 4'h0;
        tick();
        load(5'd0);

        // sticky overflow flag
        ovf_force = 1'b1;
        settle();
        chk("ovf_pre", 32'(ovf_err), 32'h0);
        tick();
        ovf_force = 1'b0;
        chk("ovf_set", 32'(ovf_err), 32'h1);
        repeat (3) tick();
        chk("ovf_sticky", 32'(ovf_err), 32'h1);

        // reset in the middle of FSH, flush request still pending afterwards
        fsh_req = 1'b1;
        tick();
        tick();
        chk("rf_fsh", 32'(bus.fifo_fsh), 32'h1);
        rstn = 1'b0;
        settle();
        chk("rf_async_fsh", 32'(bus.fifo_fsh), 32'h0);
        chk("rf_async_ovf", 32'(ovf_err),      32'h0);
        chk("rf_async_rdy", 32'(bus.req_rdy),  32'h0);
        tick();
        rstn = 1'b1;
        tick();
        chk("rf_drain_fsh",  32'(bus.fifo_fsh), 32'h0);
        chk("rf_drain_done", 32'(fsh_done),     32'h0);
        tick();
        chk("rf_fsh2", 32'(bus.fifo_fsh), 32'h1);
        tick();
        chk("rf_done2",     32'(fsh_done),     32'h1);
        chk("rf_done2_fsh", 32'(bus.fifo_fsh), 32'h0);
        fsh_req = 1'b0;
        tick();
        chk("rf_end_done", 32'(fsh_done),     32'h0);
        chk("rf_end_fsh",  32'(bus.fifo_fsh), 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/sfifo_wr_arb.md
Name: sfifo_wr_arb

Overview:
- Round-robin write arbiter and flush sequencer for the synchronous FIFO (sfifo) push port.
- Shares one push port among NREQ valid/ready requesters, one beat per cycle.
- Uses a credit check on fifo_len so the FIFO never overflows despite the registered write path.
- Sequences a flush request from the system into a clean, drained fifo_fsh pulse.

Parameters:
- NREQ, 4, number of requesters (2..8).
- FIFO_D, 12, FIFO depth; must match the attached FIFO.
- FIFO_W, 32, data width.
- FIFO_ADR, $clog2(FIFO_D), derived; never overridden.

Ports:
- clk  in  1  clock
- rstn  in  1  asynchronous active-low reset
- req_vld  in  NREQ  per-requester write valid
- req_dat  in  NREQ*FIFO_W  per-requester data; requester i occupies bits [i*FIFO_W +: FIFO_W]
- req_rdy  out  NREQ  per-requester accept, one-hot or zero
- fsh_req  in  1  flush request, level; held until fsh_done
- fsh_done  out  1  one-cycle pulse when the flush completes
- fifo_we  out  1  FIFO push, registered
- fifo_wd  out  FIFO_W  FIFO push data, registered
- fifo_fsh  out  1  FIFO flush, registered, one-cycle pulse
- fifo_full  in  1  FIFO full
- fifo_ovf  in  1  FIFO overflow indication
- fifo_len  in  FIFO_ADR+1  FIFO occupancy; includes writes up to the previous cycle
- gnt_id  out  $clog2(NREQ)  index of the last accepted requester
- ovf_err  out  1  sticky; set if fifo_ovf is ever seen; cleared only by reset

Interface: one clock clk; reset rstn is asynchronous, active-low.

Behaviour:
- Reset: fifo_we=0, fifo_wd=0, fifo_fsh=0, fsh_done=0, ovf_err=0, gnt_id=0, rr_ptr=NREQ-1, state=ARB. req_rdy is combinational and reads 0 while rstn=0.
- Credit: occ = fifo_len + fifo_we, computed at FIFO_ADR+2 bits, no wrap. can_wr = (occ < FIFO_D) && !fifo_full.
- Arbitration in ARB:
  - Search req_vld starting from rr_ptr+1, wrapping modulo NREQ.
  - The first set bit wins; req_rdy[win]=can_wr. All other bits are 0.
- Accept (req_vld[i] && req_rdy[i]):
  - Next cycle: fifo_we=1, fifo_wd=req_dat[i], gnt_id=i, rr_ptr=i.
  - Latency from accept to fifo_we is exactly 1 cycle. Throughput is one beat per cycle while credit allows.
- No accept: fifo_we=0 next cycle; fifo_wd holds its last value; rr_ptr is unchanged.
- Requester behaviour: requesters may drop req_vld without a handshake; the arbiter keeps no lock across cycles.
- FSM:
  - ARB: if fsh_req=1, go to FDRAIN. No grant is issued in the cycle fsh_req is first seen, so fsh_req has priority over a simultaneous req_vld.
  - FDRAIN: req_rdy=0. Lasts exactly 1 cycle, letting any in-flight fifo_we land. Go to FSH.
  - FSH: fifo_fsh=1 for this cycle; req_rdy=0. Go to FDONE.
  - FDONE: fsh_done=1 for this cycle; req_rdy=0. Go to ARB.
- Flush outcome: the FIFO is empty after FSH.
- rr_ptr across flush: not reset; the arbitration order continues.
- fsh_req re-sampling: fsh_req still high in the first ARB cycle after FDONE starts a new flush.
- Full boundary:
  - occ=FIFO_D-1 with no write in flight: exactly one more beat is accepted; the next cycle can_wr=0.
  - At occ=FIFO_D: req_rdy=0 until fifo_len drops.
- ovf_err: set the cycle after fifo_ovf=1. It must never fire under correct credit; it is a verification hook.
- Reset mid-operation: every state and output returns to its reset value asynchronously. A pending fsh_req is re-evaluated from ARB after reset release.

Test Plan:
- All 4 req_vld held, fifo_len=0, FIFO popped continuously -> accepts in order 0,1,2,3,0; fifo_we=1 every cycle; fifo_wd equals the accepted data one cycle later.
- Only req 2 valid, 12 beats with no pops -> 12 accepts; req_rdy[2] drops after 12 beats; fifo_full, no fifo_ovf, ovf_err=0.
- fifo_len=11, req 0 and req 1 valid on consecutive cycles -> only one accept; next cycle req_rdy=0 (occ=12).
- fsh_req raised in the same cycle req 3 is valid, with a write in flight -> no grant; FDRAIN, then fifo_fsh pulse, then fsh_done pulse (3 cycles); FIFO empty; req 3 accepted the cycle after FDONE.
- Force fifo_ovf=1 for one cycle -> ovf_err=1 and sticky until rstn=0.
- rstn asserted during FSH -> fifo_fsh=0 and state=ARB immediately; after release with fsh_req=1, the full flush sequence repeats.
